// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed little-endian word stream, writes it to imem
// and releases the CPU reset only after the trailing XOR checksum matches.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no load since reset; CPU held in reset
// LEN_LO  | waiting for word count bits [7:0]
// LEN_HI  | waiting for word count bits [15:8]
// PAYLOAD | collecting 4 bytes per word, writing each completed word
// CHECK   | waiting for the checksum byte
// DONE    | image accepted; CPU released
// ERR     | bad length, bad checksum or timeout; CPU held in reset
module imem_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wEn,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, DONE, ERR
  } state_t;

  // The timer only ever holds values below TIMEOUT_CYCLES before it forces ERR.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [16:0]   MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t        state, state_next;
  logic [15:0]   len;
  logic [15:0]   idx;
  logic [1:0]    lane;
  logic [23:0]   word_buf;
  logic [7:0]    csum;
  logic [TW-1:0] timer;
  logic [15:0]   len_full;
  logic          rx, hs, last_byte, timer_hit, idle_like;

  function automatic logic is_rx(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == PAYLOAD) || (s == CHECK);
  endfunction

  always_comb begin
    rx         = is_rx(state);
    hs         = in_valid && rx;
    idle_like  = (state == IDLE) || (state == DONE) || (state == ERR);
    len_full   = {in_data, len[7:0]};
    last_byte  = (lane == 2'd3) && (idx == len - 16'd1);
    timer_hit  = (TIMEOUT_CYCLES > 0) && rx && !hs && (timer == TMO_LAST);
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN_LO;
      LEN_LO:          if (hs) state_next = LEN_HI;
      LEN_HI: begin
        if (hs) begin
          if ({1'b0, len_full} > MAX_WORDS) state_next = ERR;
          else if (len_full == 16'd0)       state_next = CHECK;
          else                              state_next = PAYLOAD;
        end
      end
      PAYLOAD:         if (hs && last_byte) state_next = CHECK;
      CHECK:           if (hs) state_next = (in_data == csum) ? DONE : ERR;
      default:         state_next = IDLE;
    endcase
    // A handshake in the same cycle keeps timer_hit low, so the byte always wins.
    if (timer_hit) state_next = ERR;
  end

  // Status outputs are registered from the next-state decode so they track state without lag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= is_rx(state_next);
      busy      <= is_rx(state_next);
      cpu_reset <= (state_next != DONE);
      done      <= (state_next == DONE);
      error     <= (state_next == ERR);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len      <= '0;
      idx      <= '0;
      lane     <= '0;
      word_buf <= '0;
      csum     <= '0;
      timer    <= '0;
      wEn      <= 1'b0;
      addr     <= '0;
      dataOut  <= '0;
    end else begin
      wEn <= 1'b0;
      if (hs || !rx || TIMEOUT_CYCLES == 0) timer <= '0;
      else                                   timer <= timer + 1'b1;
      if (idle_like && start) begin
        idx  <= '0;
        lane <= '0;
        csum <= '0;
      end
      case (state)
        LEN_LO: if (hs) len[7:0]  <= in_data;
        LEN_HI: if (hs) len[15:8] <= in_data;
        PAYLOAD: begin
          if (hs) begin
            csum <= csum ^ in_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                wEn     <= 1'b1;
                addr    <= idx[ADDR_WIDTH-1:0];
                dataOut <= {in_data, word_buf};
                idx     <= idx + 16'd1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed and randomized images checked against a byte-level
// image model, plus oversize length, timeout timing and mid-load reset scenarios.
module tb_imem_loader;
  localparam int AW = 12;
  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, wEn, cpu_reset, busy, done, error;
  logic [AW-1:0] addr;
  logic [31:0] dataOut;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  s[$];
  logic [43:0] got_wr[$];
  logic [43:0] exp_wr[$];
  bit exp_done, exp_err;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wEn(wEn), .addr(addr), .dataOut(dataOut),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error));

  always #5 clock = ~clock;

  always @(negedge clock) if (wEn === 1'b1) got_wr.push_back({addr, dataOut});

  // Image model: length, little-endian words at consecutive addresses, XOR of payload bytes.
  task automatic model_image();
    int n;
    logic [7:0] cs;
    exp_wr.delete();
    n = int'({s[1], s[0]});
    if (n > (1 << AW)) begin
      exp_done = 0; exp_err = 1;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      int k = 2 + 4 * i;
      exp_wr.push_back({AW'(i), s[k+3], s[k+2], s[k+1], s[k]});
      cs = cs ^ s[k] ^ s[k+1] ^ s[k+2] ^ s[k+3];
    end
    exp_done = (s[2 + 4 * n] == cs);
    exp_err  = !exp_done;
  endtask

  task automatic build_random(input bit allow_bad);
    logic [15:0] n16;
    logic [7:0]  b, cs;
    s.delete();
    n16 = 16'($urandom_range(0, 5));
    s.push_back(n16[7:0]);
    s.push_back(n16[15:8]);
    cs = 8'h00;
    for (int i = 0; i < 4 * int'(n16); i++) begin
      b = 8'($urandom);
      s.push_back(b);
      cs ^= b;
    end
    if (allow_bad && $urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
    s.push_back(cs);
  endtask

  task automatic cycle();
    @(posedge clock); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic send_stream(input int first, input int last, input int gapmax);
    int gap;
    for (int i = first; i <= last; i++) begin
      in_valid = 1'b1; in_data = s[i];
      cycle();
      in_valid = 1'b0; in_data = 8'($urandom);
      gap = $urandom_range(0, gapmax);
      repeat (gap) cycle();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2 reset = 1'b0;
    #2;
    n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    n_cmp++; if (wEn !== 1'b0)       begin n_bad++; $display("FAIL reset wEn: got %b want 0", wEn); end
    n_cmp++; if (addr !== '0)        begin n_bad++; $display("FAIL reset addr: got %h want 0", addr); end
    n_cmp++; if (dataOut !== '0)     begin n_bad++; $display("FAIL reset dataOut: got %h want 0", dataOut); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL reset cpu_reset: got %b want 1", cpu_reset); end
    n_cmp++; if ({busy, done, error} !== 3'b000) begin n_bad++; $display("FAIL reset busy/done/error: got %b want 000", {busy, done, error}); end
    cycle();
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_spec_streams();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        1: s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
        2: s = '{8'h00, 8'h00, 8'h00};
        default: s = '{8'h00, 8'h00, 8'h01};
      endcase
      model_image();
      got_wr.delete();
      pulse_start();
      send_stream(0, s.size() - 1, 0);
      n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL spec%0d done: got %b want %b", c, done, exp_done); end
      n_cmp++; if (error !== exp_err) begin n_bad++; $display("FAIL spec%0d error: got %b want %b", c, error, exp_err); end
      n_cmp++; if (cpu_reset !== !exp_done) begin n_bad++; $display("FAIL spec%0d cpu_reset: got %b want %b", c, cpu_reset, !exp_done); end
      cycle();
      n_cmp++; if (got_wr.size() !== exp_wr.size()) begin n_bad++; $display("FAIL spec%0d write count: got %0d want %0d", c, got_wr.size(), exp_wr.size()); end
      else for (int i = 0; i < exp_wr.size(); i++) begin
        n_cmp++; if (got_wr[i] !== exp_wr[i]) begin n_bad++; $display("FAIL spec%0d write %0d: got %h want %h", c, i, got_wr[i], exp_wr[i]); end
      end
    end
  endtask

  task automatic test_oversize();
    s = '{8'h01, 8'h10};
    repeat (8) s.push_back(8'($urandom));
    got_wr.delete();
    pulse_start();
    send_stream(0, 1, 0);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL oversize error after LEN_HI: got %b want 1", error); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL oversize in_ready: got %b want 0", in_ready); end
    send_stream(2, s.size() - 1, 1);
    cycle();
    n_cmp++; if ({error, done, cpu_reset} !== 3'b101) begin n_bad++; $display("FAIL oversize final error/done/cpu_reset: got %b want 101", {error, done, cpu_reset}); end
    n_cmp++; if (got_wr.size() !== 0) begin n_bad++; $display("FAIL oversize writes: got %0d want 0", got_wr.size()); end
  endtask

  task automatic test_timeout();
    s = '{8'h02, 8'h00, 8'h78, 8'h56};
    pulse_start();
    send_stream(0, 2, 0);
    for (int k = 1; k <= 16; k++) begin
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL timeout early at idle cycle %0d: got %b want 0", k, error); end
      cycle();
    end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL timeout at cycle 17: got %b want 1", error); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout busy: got %b want 0", busy); end
    pulse_start();
    send_stream(0, 2, 0);
    repeat (15) cycle();
    send_stream(3, 3, 0);
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if ({error, busy} !== 2'b01) begin n_bad++; $display("FAIL timeout rescued %0d error/busy: got %b want 01", k, {error, busy}); end
      cycle();
    end
    repeat (10) cycle();
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL timeout second stall: got %b want 1", error); end
  endtask

  task automatic test_reset_midload();
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    got_wr.delete();
    pulse_start();
    send_stream(0, 2, 0);
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start-during-busy busy: got %b want 1", busy); end
    send_stream(3, 6, 0);
    n_cmp++; if (got_wr.size() !== 1 || got_wr[0] !== {12'h000, 32'h12345678}) begin
      n_bad++; $display("FAIL midload write: got %0d writes want 1 at 000/12345678", got_wr.size()); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({in_ready, wEn, cpu_reset, busy, done, error} !== 6'b001000) begin n_bad++; $display("FAIL midload reset outputs: got %b want 001000", {in_ready, wEn, cpu_reset, busy, done, error}); end
    n_cmp++; if ({addr, dataOut} !== '0) begin n_bad++; $display("FAIL midload reset addr/data: got %h want 0", {addr, dataOut}); end
    cycle();
    reset = 1'b1;
    cycle();
    got_wr.delete();
    pulse_start();
    send_stream(0, s.size() - 1, 0);
    cycle();
    n_cmp++; if ({done, error, cpu_reset} !== 3'b100) begin n_bad++; $display("FAIL reload done/error/cpu_reset: got %b want 100", {done, error, cpu_reset}); end
    n_cmp++; if (got_wr.size() !== 2) begin n_bad++; $display("FAIL reload write count: got %0d want 2", got_wr.size()); end
  endtask

  task automatic test_random(input int iters, input int gapmax);
    for (int it = 0; it < iters; it++) begin
      build_random(1'b1);
      model_image();
      got_wr.delete();
      pulse_start();
      send_stream(0, s.size() - 1, gapmax);
      cycle();
      n_cmp++; if ({done, error, cpu_reset} !== {exp_done, exp_err, !exp_done}) begin
        n_bad++; $display("FAIL rand%0d_%0d done/error/cpu_reset: got %b want %b", gapmax, it, {done, error, cpu_reset}, {exp_done, exp_err, !exp_done}); end
      n_cmp++; if (got_wr.size() !== exp_wr.size()) begin n_bad++; $display("FAIL rand%0d_%0d write count: got %0d want %0d", gapmax, it, got_wr.size(), exp_wr.size()); end
      else for (int i = 0; i < exp_wr.size(); i++) begin
        n_cmp++; if (got_wr[i] !== exp_wr[i]) begin n_bad++; $display("FAIL rand%0d_%0d write %0d: got %h want %h", gapmax, it, i, got_wr[i], exp_wr[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_streams();
    test_oversize();
    test_timeout();
    test_reset_midload();
    test_random(20, 5);
    test_random(10, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
